// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches to
// instruction memory, buffers responses in a small prefetch queue and hands them to
// decode. Redirects flush the queue and discard any in-flight response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        id_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  // RUN: idle, WAIT: response will be kept, DROP: response will be discarded
  typedef enum logic [1:0] {StRun, StWait, StDrop} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [31:0]        q_pc_q [DEPTH];
  logic [31:0]        q_pc_d [DEPTH];
  logic [31:0]        q_instr_q [DEPTH];
  logic [31:0]        q_instr_d [DEPTH];

  logic accept, push, pop;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Memory-side request and decode-side head outputs
  always_comb begin
    imem_req    = (state_q == StRun) && (count_q < DepthCnt) && !redirect_valid;
    imem_addr   = fetch_pc_q;
    instr_valid = (count_q != '0);
    instr       = instr_valid ? q_instr_q[rd_ptr_q] : 32'h0000_0000;
    instr_pc    = instr_valid ? q_pc_q[rd_ptr_q] : 32'h0000_0000;
    accept      = imem_req && imem_ready;
    // Redirect voids both the pending push and any simultaneous pop
    push        = (state_q == StWait) && imem_rvalid && !redirect_valid;
    pop         = instr_valid && id_ready && !redirect_valid;
  end

  // Fetch state machine next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:  if (accept) state_d = StWait;
      StWait: begin
        if (redirect_valid) state_d = imem_rvalid ? StRun : StDrop;
        else if (imem_rvalid) state_d = StRun;
      end
      StDrop: if (imem_rvalid) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // PC, queue pointers, occupancy and queue storage next state
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    q_pc_d     = q_pc_q;
    q_instr_d  = q_instr_q;

    if (accept) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        q_pc_d[wr_ptr_q]    = req_pc_q;
        q_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      fetch_pc_q <= ResetPcAligned;
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      q_pc_q     <= '{default: '0};
      q_instr_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      q_pc_q     <= q_pc_d;
      q_instr_q  <= q_instr_d;
    end
  end

endmodule
